// File: rtl/cfg_lut_array_if.sv
// Config/lookup bundle for cfg_lut_array.
// CFG_LUT_CHAIN_EN adds cfg_dout for daisy-chaining tiles.
interface cfg_lut_array_if #(
  parameter int K = 4,
  parameter int M = 1
) ();
  logic         cfg_start;
  logic         cfg_din_vld;
  logic         cfg_din;
  logic         cfg_busy;
  logic         cfg_ready;
  logic         cfg_done;
  logic         in_vld;
  logic [K-1:0] addr;
  logic         out_vld;
  logic [M-1:0] dout;
`ifdef CFG_LUT_CHAIN_EN
  logic         cfg_dout;
`endif

  modport master (
    output cfg_start,
    output cfg_din_vld,
    output cfg_din,
    input  cfg_busy,
    input  cfg_ready,
    input  cfg_done,
    output in_vld,
    output addr,
    input  out_vld,
`ifdef CFG_LUT_CHAIN_EN
    input  cfg_dout,
`endif
    input  dout
  );

  modport slave (
    input  cfg_start,
    input  cfg_din_vld,
    input  cfg_din,
    output cfg_busy,
    output cfg_ready,
    output cfg_done,
    input  in_vld,
    input  addr,
    output out_vld,
`ifdef CFG_LUT_CHAIN_EN
    output cfg_dout,
`endif
    output dout
  );
endinterface

// File: rtl/cfg_lut_array.sv
// K-input, M-channel LUT with shadowed serial load and atomic commit.
// CFG_LUT_CHAIN_EN exposes shadow MSB as cfg_dout for chaining.
module cfg_lut_array #(
  parameter int K = 4,
  parameter int M = 1
) (
  input logic         clk,
  input logic         rst,
  cfg_lut_array_if.slave bus
);
  localparam int N  = 1 << K;
  localparam int D  = M * N;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {
    UNCFG,
    LOAD,
    RUN
  } state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   shadow_q, shadow_d;
  logic [D-1:0]   table_q, table_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic           ovld_q, ovld_d;
  logic [M-1:0]   dout_q, dout_d;
  logic [M-1:0]   rd;
  logic [D-1:0]   shifted;
  logic           last;
  logic           serve;

  assign shifted = {shadow_q[D-2:0], bus.cfg_din};
  assign last    = (cnt_q == CW'(D - 1));

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    table_d  = table_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    unique case (state_q)
      UNCFG: begin
        if (bus.cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // restart wins over commit; a bit valid with it is bit one
        if (bus.cfg_start) begin
          cnt_d = '0;
          if (bus.cfg_din_vld) begin
            shadow_d = shifted;
            cnt_d    = CW'(1);
          end
        end else if (bus.cfg_din_vld) begin
          shadow_d = shifted;
          if (last) begin
            table_d = shifted;
            cnt_d   = '0;
            state_d = RUN;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RUN: begin
        if (bus.cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = UNCFG;
    endcase
    busy_d = (state_d == LOAD);
  end

  always_comb begin
    rd = '0;
    for (int m = 0; m < M; m++) begin
      rd[m] = table_q[m*N + int'(bus.addr)];
    end
  end

  // ready only rises on a commit, so it gates lookups in every state
  assign serve  = bus.in_vld & ready_q;
  assign ovld_d = serve;
  assign dout_d = serve ? rd : dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= UNCFG;
      shadow_q <= '0;
      table_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      ovld_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      table_q  <= table_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      ovld_q   <= ovld_d;
      dout_q   <= dout_d;
    end
  end

  assign bus.cfg_busy  = busy_q;
  assign bus.cfg_ready = ready_q;
  assign bus.cfg_done  = done_q;
  assign bus.out_vld   = ovld_q;
  assign bus.dout      = dout_q;

`ifdef CFG_LUT_CHAIN_EN
  assign bus.cfg_dout = shadow_q[D-1];
`endif
endmodule
